// File: rtl/fsm_serial_pkg.sv
// Shared state encodings and line levels for the serial-line FSM blocks.
package fsm_serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/fsm_serial_tx_if.sv
// Word handshake into the serial transmitter.
interface fsm_serial_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/fsm_serial_tx_bit_timer.sv
// Per-bit cycle counter; tc marks the last cycle of the current bit.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  // With one cycle per bit the counter never leaves 0 and tc is constant.
  assign tc = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= tc ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/fsm_serial_tx.sv
// Serial frame transmitter: start, DATA_W bits LSB-first, optional even parity, stop.
module fsm_serial_tx
  import fsm_serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  fsm_serial_tx_if.slave   bus,
  output logic             tx_out,
  output logic             busy
);
  localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shnext;
  logic [IW-1:0]     idx;
  logic              par;
  logic              tc;
  logic              accept;

  assign bus.tx_ready = (state == IDLE) & ~rst;
  assign accept       = bus.tx_valid & (state == IDLE);
  assign shnext       = shreg >> 1;

  // Timer is held at zero while idle so every frame starts with a full start bit.
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .en  (1'b1),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tx_out <= LINE_IDLE;
      busy   <= 1'b0;
      shreg  <= '0;
      idx    <= '0;
      par    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          shreg  <= bus.tx_data;
          par    <= ^bus.tx_data;
          idx    <= '0;
          state  <= START;
          tx_out <= LINE_START;
          busy   <= 1'b1;
        end
        START: if (tc) begin
          state  <= DATA;
          tx_out <= shreg[0];
        end
        DATA: if (tc) begin
          shreg <= shnext;
          if (idx == IW'(DATA_W - 1)) begin
            idx <= '0;
            if (PARITY_EN) begin
              state  <= PARITY;
              tx_out <= par;
            end else begin
              state  <= STOP;
              tx_out <= LINE_IDLE;
            end
          end else begin
            idx    <= idx + 1'b1;
            tx_out <= shnext[0];
          end
        end
        PARITY: if (tc) begin
          state  <= STOP;
          tx_out <= LINE_IDLE;
        end
        STOP: if (tc) begin
          state  <= IDLE;
          tx_out <= LINE_IDLE;
          busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          tx_out <= LINE_IDLE;
          busy   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fsm_serial_tx.sv
// Bench for fsm_serial_tx: three parameterisations against a frame-level model.
module tb_fsm_serial_tx;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] val;
  logic [7:0]    dat [NI];
  wire  [NI-1:0] out, bsy, rdy;

  int passed = 0;
  int total  = 0;

  fsm_serial_tx_if #(.DATA_W(8)) if0 ();
  fsm_serial_tx_if #(.DATA_W(8)) if1 ();
  fsm_serial_tx_if #(.DATA_W(8)) if2 ();

  assign if0.tx_valid = val[0]; assign if0.tx_data = dat[0]; assign rdy[0] = if0.tx_ready;
  assign if1.tx_valid = val[1]; assign if1.tx_data = dat[1]; assign rdy[1] = if1.tx_ready;
  assign if2.tx_valid = val[2]; assign if2.tx_data = dat[2]; assign rdy[2] = if2.tx_ready;

  fsm_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .bus(if0), .tx_out(out[0]), .busy(bsy[0]));
  fsm_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .bus(if1), .tx_out(out[1]), .busy(bsy[1]));
  fsm_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b1)) u2 (
    .clk(clk), .rst(rst), .bus(if2), .tx_out(out[2]), .busy(bsy[2]));

  function automatic int cpb(input int i);
    return (i == 2) ? 1 : 4;
  endfunction
  function automatic int pen(input int i);
    return (i == 1) ? 0 : 1;
  endfunction
  function automatic int flen(input int i);
    return (10 + pen(i)) * cpb(i);
  endfunction
  // Line levels of a whole frame, bit k = k-th bit on the wire (start first).
  function automatic logic [18:0] frame_bits(input logic [7:0] d, input int p);
    logic [18:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int j = 0; j < 8; j++) b[1+j] = d[j];
    if (p != 0) b[9] = ^d;
    return b;
  endfunction

  // Model: a frame is just "cycles since accept"; the line shows bit t/CPB.
  logic [NI-1:0] m_act = '0;
  int            m_t [NI];
  logic [18:0]   m_bits [NI];

  always @(posedge clk or posedge rst) begin
    if (rst) m_act <= '0;
    else begin
      for (int i = 0; i < NI; i++) begin
        if (m_act[i]) begin
          if (m_t[i] + 1 >= flen(i)) m_act[i] <= 1'b0;
          m_t[i] <= m_t[i] + 1;
        end else if (val[i]) begin
          m_act[i]  <= 1'b1;
          m_t[i]    <= 0;
          m_bits[i] <= frame_bits(dat[i], pen(i));
        end
      end
    end
  end

  task automatic check(input string nm, input int i, input logic a, input logic e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s[%0d] got %b want %b at %0t", nm, i, a, e, $time);
  endtask

  task automatic check_int(input string nm, input int a, input int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s got %0d want %0d at %0t", nm, a, e, $time);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check("ready", i, rdy[i], !m_act[i] && !rst);
      check("busy",  i, bsy[i], m_act[i]);
      check("line",  i, out[i], m_act[i] ? m_bits[i][m_t[i] / cpb(i)] : 1'b1);
    end
  end

  // Start a frame from idle and record one line sample per bit until busy drops.
  task automatic send(input int i, input logic [7:0] d,
                      output logic [18:0] seq, output int len, output int rlow);
    seq  = '1;
    len  = 0;
    rlow = 0;
    val[i] = 1'b1;
    dat[i] = d;
    @(negedge clk);
    val[i] = 1'b0;
    dat[i] = ~d;
    while (bsy[i] && len < 200) begin
      if (len % cpb(i) == 0) seq[len / cpb(i)] = out[i];
      if (!rdy[i]) rlow++;
      len++;
      @(negedge clk);
    end
  endtask

  logic [18:0] seq;
  int len, rlow, n, idle;

  initial begin
    val = '0;
    for (int i = 0; i < NI; i++) dat[i] = 8'h00;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_line",  0, out[0], 1'b1);
    check("rst_busy",  0, bsy[0], 1'b0);
    check("rst_ready", 0, rdy[0], 1'b0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 0, rdy[0], 1'b1);

    send(0, 8'hA5, seq, len, rlow);
    check_int("a5_seq",   int'(seq[10:0]), int'(11'b10_1010_0101_0));
    check_int("a5_len",   len, 44);
    check_int("a5_rlow",  rlow, 44);
    repeat (2) @(negedge clk);

    send(0, 8'h01, seq, len, rlow);
    check_int("p01_seq",  int'(seq[10:0]), int'(11'b11_0000_0001_0));
    check_int("p01_len",  len, 44);
    send(1, 8'h01, seq, len, rlow);
    check_int("np01_seq", int'(seq[9:0]), int'(10'b1_0000_0001_0));
    check_int("np01_len", len, 40);
    check_int("np01_rlow", rlow, 40);
    repeat (2) @(negedge clk);

    // Back-to-back: valid held high, second word presented as soon as first is taken.
    val[0] = 1'b1;
    dat[0] = 8'h3C;
    @(negedge clk);
    dat[0] = 8'hC3;
    n = 0;
    while (bsy[0] && n < 200) begin n++; @(negedge clk); end
    check_int("b2b_len1", n, 44);
    idle = 0;
    while (!bsy[0] && idle < 10) begin
      check("b2b_gap_line", 0, out[0], 1'b1);
      idle++;
      @(negedge clk);
    end
    val[0] = 1'b0;
    check_int("b2b_gap", idle, 1);
    check("b2b_start2", 0, out[0], 1'b0);
    n = 0;
    while (bsy[0] && n < 200) begin n++; @(negedge clk); end
    check_int("b2b_len2", n, 44);
    repeat (2) @(negedge clk);

    // Reset in the middle of a 0xFF frame, then a clean 0x00 frame.
    val[0] = 1'b1;
    dat[0] = 8'hFF;
    @(negedge clk);
    val[0] = 1'b0;
    repeat (16) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_line", 0, out[0], 1'b1);
    check("midrst_busy", 0, bsy[0], 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    send(0, 8'h00, seq, len, rlow);
    check_int("z_seq", int'(seq[10:0]), int'(11'b10_0000_0000_0));
    check_int("z_len", len, 44);

    send(2, 8'h80, seq, len, rlow);
    check_int("c1_seq", int'(seq[10:0]), int'(11'b11_1000_0000_0));
    check_int("c1_len", len, 11);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
